// File: rtl/tape_centroid_tracker.sv
// ---------------------------------------------------------------------------
// tape_centroid_tracker
//
// Per-frame tape localiser fed by the yellow-pixel detector. Pixel
// coordinates are generated locally from the raster-order strobes. Hit count
// and coordinate sums are accumulated over a frame. The centroid is then
// computed with two parallel restoring dividers. One result per frame is
// offered on a valid/ready handshake.
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   pix_valid        pixel strobe; pix_sof/pix_eol/tape_hit sampled only when high
//   pix_sof          first pixel of a frame, coordinate (0,0)
//   pix_eol          last pixel of a line (authoritative for line length)
//   tape_hit         colour detector hit for this pixel
//   out_valid        result available (held until accepted)
//   out_ready        consumer accepts the result
//   out_found        hit count >= MIN_PIXELS
//   out_x, out_y     floored centroid, 0 when not found
//   out_count        saturating hit count
//   busy             accumulating or dividing
//   frame_err        one-cycle pulse on a framing violation
// ---------------------------------------------------------------------------
module tape_centroid_tracker #(
    parameter  int unsigned IMG_W      = 640,
    parameter  int unsigned IMG_H      = 480,
    parameter  int unsigned COORD_W    = 10,
    parameter  int unsigned MIN_PIXELS = 64,
    localparam int unsigned CNT_W      = $clog2(IMG_W * IMG_H + 1),
    localparam int unsigned SUM_W      = COORD_W + CNT_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_valid,
    input  logic               pix_sof,
    input  logic               pix_eol,
    input  logic               tape_hit,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_found,
    output logic [COORD_W-1:0] out_x,
    output logic [COORD_W-1:0] out_y,
    output logic [CNT_W-1:0]   out_count,
    output logic               busy,
    output logic               frame_err
);

    localparam int unsigned        DCNT_W    = $clog2(SUM_W + 1);
    localparam logic [COORD_W-1:0] X_LIM     = COORD_W'(IMG_W);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0]   MIN_CNT   = CNT_W'(MIN_PIXELS);
    localparam logic [DCNT_W-1:0]  DIV_STEPS = DCNT_W'(SUM_W);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DIVIDE,
        S_HOLD
    } state_e;

    state_e              state_q;
    logic [COORD_W-1:0]  x_q, y_q;
    logic [CNT_W-1:0]    count_q;
    logic [SUM_W-1:0]    sum_x_q, sum_y_q;
    logic                div_en_q;
    logic [DCNT_W-1:0]   div_cnt_q;
    logic [SUM_W-1:0]    dvd_x_q, dvd_y_q;
    logic [CNT_W-1:0]    rem_x_q, rem_y_q;

    logic                out_valid_q, out_found_q, busy_q, frame_err_q;
    logic [COORD_W-1:0]  out_x_q, out_y_q;
    logic [CNT_W-1:0]    out_count_q;

    // Accumulator next-state for the pixel currently presented.
    logic [COORD_W-1:0]  cur_x, cur_y;
    logic [CNT_W-1:0]    base_count;
    logic [SUM_W-1:0]    base_sx, base_sy;
    logic [CNT_W-1:0]    count_d;
    logic [SUM_W-1:0]    sum_x_d, sum_y_d;
    logic [COORD_W-1:0]  x_d, y_d;
    logic                eof_d, found_d;

    // A sof pixel is treated as sitting at (0,0) on top of cleared
    // accumulators, so IDLE start and mid-frame restart share one path.
    always_comb begin
        cur_x      = pix_sof ? '0 : x_q;
        cur_y      = pix_sof ? '0 : y_q;
        base_count = pix_sof ? '0 : count_q;
        base_sx    = pix_sof ? '0 : sum_x_q;
        base_sy    = pix_sof ? '0 : sum_y_q;

        count_d = base_count;
        sum_x_d = base_sx;
        sum_y_d = base_sy;
        if (tape_hit && (cur_x < X_LIM)) begin
            if (base_count != '1) begin
                count_d = base_count + 1'b1;
            end
            sum_x_d = base_sx + SUM_W'(cur_x);
            sum_y_d = base_sy + SUM_W'(cur_y);
        end

        if (pix_eol) begin
            x_d = '0;
            y_d = cur_y + 1'b1;
        end else begin
            x_d = (cur_x == X_LIM) ? X_LIM : cur_x + 1'b1;
            y_d = cur_y;
        end

        eof_d   = pix_eol && (cur_y == Y_LAST);
        found_d = (count_d >= MIN_CNT);
    end

    // One restoring-division step per cycle for each axis. The remainder is
    // always below the divisor, so the subtraction fits in CNT_W bits.
    logic [CNT_W:0]     rem_sh_x, rem_sh_y;
    logic               ge_x, ge_y;
    logic [CNT_W-1:0]   rem_x_d, rem_y_d;
    logic [SUM_W-1:0]   dvd_x_d, dvd_y_d;

    always_comb begin
        rem_sh_x = {rem_x_q, dvd_x_q[SUM_W-1]};
        rem_sh_y = {rem_y_q, dvd_y_q[SUM_W-1]};
        ge_x     = (rem_sh_x >= {1'b0, count_q});
        ge_y     = (rem_sh_y >= {1'b0, count_q});
        rem_x_d  = ge_x ? (rem_sh_x[CNT_W-1:0] - count_q) : rem_sh_x[CNT_W-1:0];
        rem_y_d  = ge_y ? (rem_sh_y[CNT_W-1:0] - count_q) : rem_sh_y[CNT_W-1:0];
        dvd_x_d  = {dvd_x_q[SUM_W-2:0], ge_x};
        dvd_y_d  = {dvd_y_q[SUM_W-2:0], ge_y};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            x_q         <= '0;
            y_q         <= '0;
            count_q     <= '0;
            sum_x_q     <= '0;
            sum_y_q     <= '0;
            div_en_q    <= 1'b0;
            div_cnt_q   <= '0;
            dvd_x_q     <= '0;
            dvd_y_q     <= '0;
            rem_x_q     <= '0;
            rem_y_q     <= '0;
            out_valid_q <= 1'b0;
            out_found_q <= 1'b0;
            out_x_q     <= '0;
            out_y_q     <= '0;
            out_count_q <= '0;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= 1'b0;
            case (state_q)
                S_IDLE, S_ACCUM: begin
                    if (pix_valid && (pix_sof || (state_q == S_ACCUM))) begin
                        if ((state_q == S_ACCUM) && pix_sof) begin
                            frame_err_q <= 1'b1;
                        end
                        x_q     <= x_d;
                        y_q     <= y_d;
                        count_q <= count_d;
                        sum_x_q <= sum_x_d;
                        sum_y_q <= sum_y_d;
                        busy_q  <= 1'b1;
                        if (eof_d) begin
                            // Both outcomes pass through DIVIDE: a not-found
                            // frame spends a single cycle there, which gives
                            // the one-cycle result latency.
                            state_q   <= S_DIVIDE;
                            div_en_q  <= found_d;
                            div_cnt_q <= '0;
                            dvd_x_q   <= sum_x_d;
                            dvd_y_q   <= sum_y_d;
                            rem_x_q   <= '0;
                            rem_y_q   <= '0;
                        end else begin
                            state_q <= S_ACCUM;
                        end
                    end
                end
                S_DIVIDE: begin
                    if (pix_valid && pix_sof) begin
                        frame_err_q <= 1'b1;
                    end
                    if (!div_en_q || (div_cnt_q == DIV_STEPS)) begin
                        state_q     <= S_HOLD;
                        busy_q      <= 1'b0;
                        out_valid_q <= 1'b1;
                        out_found_q <= div_en_q;
                        out_x_q     <= div_en_q ? dvd_x_q[COORD_W-1:0] : '0;
                        out_y_q     <= div_en_q ? dvd_y_q[COORD_W-1:0] : '0;
                        out_count_q <= count_q;
                    end else begin
                        dvd_x_q   <= dvd_x_d;
                        dvd_y_q   <= dvd_y_d;
                        rem_x_q   <= rem_x_d;
                        rem_y_q   <= rem_y_d;
                        div_cnt_q <= div_cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (pix_valid && pix_sof) begin
                        frame_err_q <= 1'b1;
                    end
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_found = out_found_q;
    assign out_x     = out_x_q;
    assign out_y     = out_y_q;
    assign out_count = out_count_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule

// File: doc/tape_centroid_tracker.md
# tape_centroid_tracker

Per-frame tape localiser that sits directly downstream of the yellow-pixel colour detector. It consumes the detector's per-pixel hit flag in raster order and generates pixel coordinates locally. Over each frame it accumulates the hit count and coordinate sums, then computes the tape centroid with a sequential divider. It presents one result per frame to the steering logic over a valid/ready handshake.

## Interface
- `IMG_W`, default 640: active pixels per line.
- `IMG_H`, default 480: active lines per frame.
- `COORD_W`, default 10: width of x/y coordinates.
- `MIN_PIXELS`, default 64: minimum hit count for a frame to report tape found.
- Derived: `CNT_W` = clog2(IMG_W*IMG_H+1); `SUM_W` = COORD_W+CNT_W.
- `clk`  in  1  sole clock, all logic rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pix_valid`  in  1  pixel strobe; other pixel inputs are sampled only when this is high.
- `pix_sof`  in  1  first pixel of a frame, at coordinate (0,0).
- `pix_eol`  in  1  last pixel of a line.
- `tape_hit`  in  1  colour detector hit for this pixel.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer accepts the result.
- `out_found`  out  1  hit count ≥ MIN_PIXELS.
- `out_x`  out  COORD_W  centroid x (floor); 0 if not found.
- `out_y`  out  COORD_W  centroid y (floor); 0 if not found.
- `out_count`  out  CNT_W  hit count, saturating at all-ones.
- `busy`  out  1  high in ACCUM or DIVIDE.
- `frame_err`  out  1  one-cycle pulse on a framing violation.

## Operation
- States: IDLE, ACCUM, DIVIDE, HOLD.
- **IDLE**
  - Waits for `pix_valid && pix_sof`.
  - On that pixel: set x=0, y=0; clear count and sums; accumulate the pixel; go to ACCUM.
  - Pixels without sof are ignored.
- **ACCUM**, on each valid pixel:
  - If `tape_hit` and x<IMG_W: count+=1, sum_x+=x, sum_y+=y.
  - If `pix_eol`: x←0, y←y+1. Otherwise x←x+1, saturating at IMG_W.
  - eol is authoritative for line length.
  - End of frame is a valid pixel with eol while y==IMG_H-1. That pixel is accumulated first, then the block leaves ACCUM.
    - If count ≥ MIN_PIXELS: go to DIVIDE.
    - Otherwise: go to HOLD with out_found=0, out_x=0, out_y=0.
  - `pix_sof` in ACCUM: pulse frame_err, then restart accumulation at (0,0) with that pixel included.
- **DIVIDE**
  - Two parallel restoring dividers, one quotient bit per cycle, exactly SUM_W cycles.
  - Computes sum_x/count and sum_y/count; quotients are truncated to COORD_W.
  - Then go to HOLD with out_found=1.
- **HOLD**
  - out_valid=1; all out_* stay stable until the `out_valid && out_ready` cycle, then go to IDLE.
- Pixels arriving in DIVIDE or HOLD are discarded.
  - A `pix_sof` among them pulses frame_err; that frame is dropped entirely.
  - The block resynchronises only on a sof seen in IDLE.
- Width rules:
  - Sums are SUM_W bits unsigned and cannot overflow.
  - Count increments are blocked at all-ones.

## Timing
- Reset (`rst_n` low, asynchronous):
  - State←IDLE.
  - out_valid, out_found, out_x, out_y, out_count, busy, frame_err all 0.
  - Accumulators cleared.
- Reset mid-frame or mid-divide discards all work; outputs go to 0 without waiting for a clock edge.
- Let the last pixel of a frame be sampled at edge k.
  - Found case: DIVIDE occupies edges k+1 … k+SUM_W; out_valid is high after edge k+SUM_W+1.
  - Not-found case: out_valid is high after edge k+1.
- Handshake:
  - out_valid never drops without `out_ready`.
  - Acceptance is on the edge where both are high.
  - If out_ready is already high, out_valid is high for exactly one cycle.
  - The earliest sof accepted after a handshake is on the edge following the handshake edge (IDLE).
- frame_err is registered and asserts for the cycle after the offending pixel edge.
- busy is registered: high from the edge after the sof pixel through the last DIVIDE cycle.

## Test plan
Parameters for all scenarios: IMG_W=8, IMG_H=4, MIN_PIXELS=2, COORD_W=10, giving SUM_W=16. out_ready is held high unless stated.
- **Basic centroid.** Hits at (2,1), (4,1), (3,3) → out_found=1, out_count=3, out_x=3, out_y=1; out_valid rises 17 cycles after the last pixel.
- **Below threshold.** A single hit at (5,2) → out_found=0, out_x=0, out_y=0, out_count=1; out_valid rises 1 cycle after the last pixel.
- **Full frame, gapped input.** All 32 pixels hit, with pix_valid deasserted on random cycles → out_count=32, out_x=3, out_y=1.
- **Backpressure.** out_ready low for 50 cycles while a second frame's sof arrives → outputs held stable; one frame_err pulse; the second frame produces no result; the third frame is reported normally.
- **Mid-frame restart.** sof arrives at (4,2) → frame_err pulse; the result reflects only pixels from the new sof onward.
- **Reset mid-divide.** rst_n pulsed low during DIVIDE → all outputs 0 immediately; no out_valid appears; the next frame is reported correctly.
